// File: rtl/bpu_update_queue_pkg.sv
// Shared definitions for the branch-predictor update queue: the branch type
// encoding, the FIFO record layout and the fix-up PC helper.
package bpu_update_queue_pkg;

    typedef enum logic [2:0] {
        BR_NOP    = 3'd0,
        BR_COND   = 3'd1,
        BR_DIRECT = 3'd2,
        BR_CALL   = 3'd3,
        BR_RET    = 3'd4,
        BR_INDIR  = 3'd5
    } br_type_t;

    // One retired branch waiting to be trained into the predictor.
    typedef struct packed {
        logic [31:0] pc;
        br_type_t    br_type;
        logic        taken;
        logic [31:0] target;
        logic        tgt_wrong;
    } bpu_upd_rec_t;

    localparam int REC_W = $bits(bpu_upd_rec_t);

    // Correct next fetch PC for a resolved branch; pc+4 wraps at 32 bits.
    function automatic logic [31:0] calc_fix_pc(input logic [31:0] pc,
                                                input logic        taken,
                                                input logic [31:0] target);
        return taken ? target : (pc + 32'd4);
    endfunction

endpackage

// File: rtl/bpu_update_queue_if.sv
// Commit / redirect / training signal bundle for bpu_update_queue.
// master = commit stage, front end and predictor; slave = the update queue.
// Handshake: a commit slot is taken on a rising edge where cm_valid_x and
// cm_ready are both high. cm_ready depends only on registered occupancy, and
// cm_valid_1 is only meaningful together with cm_valid_0. Redirect and
// training outputs are pure valid strobes with no ready: the receiver must
// take them in the cycle they are shown.
interface bpu_update_queue_if;

    logic        cm_valid_0;
    logic        cm_valid_1;
    logic        cm_ready;
    logic [31:0] cm_pc_0;
    logic [31:0] cm_pc_1;
    logic [2:0]  cm_type_0;
    logic [2:0]  cm_type_1;
    logic        cm_taken_0;
    logic        cm_taken_1;
    logic [31:0] cm_target_0;
    logic [31:0] cm_target_1;
    logic        cm_pred_taken_0;
    logic        cm_pred_taken_1;
    logic [31:0] cm_pred_target_0;
    logic [31:0] cm_pred_target_1;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        update_orien_en;
    logic [31:0] retire_pc;
    logic        right_orien;
    logic        branch_mistaken;
    logic [31:0] wrong_pc;
    logic [31:0] right_target;
    logic [2:0]  ins_type_w;

    modport master (
        output cm_valid_0, cm_valid_1, cm_pc_0, cm_pc_1, cm_type_0, cm_type_1,
               cm_taken_0, cm_taken_1, cm_target_0, cm_target_1,
               cm_pred_taken_0, cm_pred_taken_1, cm_pred_target_0, cm_pred_target_1,
        input  cm_ready, redirect_valid, redirect_pc,
               update_orien_en, retire_pc, right_orien, branch_mistaken,
               wrong_pc, right_target, ins_type_w
    );

    modport slave (
        input  cm_valid_0, cm_valid_1, cm_pc_0, cm_pc_1, cm_type_0, cm_type_1,
               cm_taken_0, cm_taken_1, cm_target_0, cm_target_1,
               cm_pred_taken_0, cm_pred_taken_1, cm_pred_target_0, cm_pred_target_1,
        output cm_ready, redirect_valid, redirect_pc,
               update_orien_en, retire_pc, right_orien, branch_mistaken,
               wrong_pc, right_target, ins_type_w
    );

endinterface

// File: rtl/bpu_upd_fifo.sv
// 2-write / 1-read circular buffer of branch records with occupancy count.
// Writes: i_push_n records (0..2) land at wptr, wptr+1 in order (rec_a first).
// The caller guarantees room for every push; storage is never cleared.
module bpu_upd_fifo
    import bpu_update_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       i_push_n,
    input  bpu_upd_rec_t     i_rec_a,
    input  bpu_upd_rec_t     i_rec_b,
    input  logic             i_pop,
    output bpu_upd_rec_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    bpu_upd_rec_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic [PTR_W-1:0] w_wptr_p1;

    assign o_empty   = (r_count == '0);
    assign w_pop     = i_pop && !o_empty;
    assign w_wptr_p1 = r_wptr + PTR_W'(1);
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    // Record storage: write up to two entries in commit order, no reset.
    always_ff @(posedge clk) begin
        if (i_push_n != 2'd0) begin
            r_mem[r_wptr] <= i_rec_a;
        end
        if (i_push_n == 2'd2) begin
            r_mem[w_wptr_p1] <= i_rec_b;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks net change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(i_push_n);
            r_rptr  <= r_rptr + PTR_W'(w_pop);
            r_count <= r_count + CNT_W'(i_push_n) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/bpu_update_queue.sv
// Commit-side branch predictor trainer. Checks up to two retired branches per
// cycle against their predictions, raises a registered redirect on the first
// mispredict, queues non-NOP records and trains one record per cycle.
// Optional feature: define BPU_PERF_CNT_EN to add perf_br_cnt / perf_mis_cnt.
module bpu_update_queue
    import bpu_update_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    bpu_update_queue_if.slave  bus
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_br_cnt,
    output logic [31:0]        perf_mis_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    logic             w_ready;
    logic             w_acc_0;
    logic             w_acc_1;
    br_type_t         w_type_0;
    br_type_t         w_type_1;
    logic             w_tgt_wrong_0;
    logic             w_tgt_wrong_1;
    logic             w_mis_0;
    logic             w_mis_1;
    logic [31:0]      w_fix_0;
    logic [31:0]      w_fix_1;
    logic             w_enq_0;
    logic             w_enq_1;
    logic             w_redirect;
    logic [31:0]      w_redirect_pc;
    logic [1:0]       w_push_n;
    bpu_upd_rec_t     w_rec_0;
    bpu_upd_rec_t     w_rec_1;
    bpu_upd_rec_t     w_rec_a;
    bpu_upd_rec_t     w_rec_b;
    bpu_upd_rec_t     w_head;

    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;

    // Accept both slots only when two entries are free, so no partial accept.
    assign w_ready      = ((DEPTH - int'(w_count)) >= 2);
    assign bus.cm_ready = w_ready;
    assign w_acc_0      = bus.cm_valid_0 && w_ready;
    assign w_acc_1      = bus.cm_valid_1 && bus.cm_valid_0 && w_ready;

    assign w_type_0 = br_type_t'(bus.cm_type_0);
    assign w_type_1 = br_type_t'(bus.cm_type_1);

    assign w_tgt_wrong_0 = bus.cm_taken_0 && (bus.cm_pred_target_0 != bus.cm_target_0);
    assign w_tgt_wrong_1 = bus.cm_taken_1 && (bus.cm_pred_target_1 != bus.cm_target_1);
    assign w_mis_0 = (bus.cm_pred_taken_0 != bus.cm_taken_0) || w_tgt_wrong_0;
    assign w_mis_1 = (bus.cm_pred_taken_1 != bus.cm_taken_1) || w_tgt_wrong_1;
    assign w_fix_0 = calc_fix_pc(bus.cm_pc_0, bus.cm_taken_0, bus.cm_target_0);
    assign w_fix_1 = calc_fix_pc(bus.cm_pc_1, bus.cm_taken_1, bus.cm_target_1);

    // A slot-0 mispredict kills slot 1: it is younger and on the wrong path.
    assign w_redirect    = (w_acc_0 && w_mis_0) || (w_acc_1 && !w_mis_0 && w_mis_1);
    assign w_redirect_pc = (w_acc_0 && w_mis_0) ? w_fix_0 : w_fix_1;

    assign w_enq_0 = w_acc_0 && (w_type_0 != BR_NOP);
    assign w_enq_1 = w_acc_1 && !w_mis_0 && (w_type_1 != BR_NOP);

    assign w_rec_0 = '{pc: bus.cm_pc_0, br_type: w_type_0, taken: bus.cm_taken_0,
                       target: bus.cm_target_0, tgt_wrong: w_tgt_wrong_0};
    assign w_rec_1 = '{pc: bus.cm_pc_1, br_type: w_type_1, taken: bus.cm_taken_1,
                       target: bus.cm_target_1, tgt_wrong: w_tgt_wrong_1};

    // Compact the enqueued slots so the oldest record always goes first.
    assign w_push_n = {1'b0, w_enq_0} + {1'b0, w_enq_1};
    assign w_rec_a  = w_enq_0 ? w_rec_0 : w_rec_1;
    assign w_rec_b  = w_rec_1;

    bpu_upd_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .i_push_n (w_push_n),
        .i_rec_a  (w_rec_a),
        .i_rec_b  (w_rec_b),
        .i_pop    (!w_empty),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_empty  (w_empty)
    );

    // Registered one-cycle redirect pulse toward the front end.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_redirect;
            r_redirect_pc    <= w_redirect ? w_redirect_pc : 32'd0;
        end
    end

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;

    // Training port shows the FIFO head for one cycle; all zero when empty.
    always_comb begin
        bus.update_orien_en = 1'b0;
        bus.retire_pc       = '0;
        bus.right_orien     = 1'b0;
        bus.branch_mistaken = 1'b0;
        bus.wrong_pc        = '0;
        bus.right_target    = '0;
        bus.ins_type_w      = '0;
        if (!w_empty) begin
            bus.update_orien_en = (w_head.br_type == BR_COND);
            bus.retire_pc       = w_head.pc;
            bus.right_orien     = w_head.taken;
            bus.branch_mistaken = w_head.tgt_wrong && (w_head.br_type != BR_INDIR);
            bus.wrong_pc        = w_head.pc;
            bus.right_target    = w_head.target;
            bus.ins_type_w      = w_head.br_type;
        end
    end

`ifdef BPU_PERF_CNT_EN
    // Performance counters: records enqueued and redirects raised, wrapping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_br_cnt  <= '0;
            perf_mis_cnt <= '0;
        end else begin
            perf_br_cnt  <= perf_br_cnt + 32'(w_push_n);
            perf_mis_cnt <= perf_mis_cnt + 32'(w_redirect);
        end
    end
`endif

endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed testbench for bpu_update_queue: queue-based reference model checked
// every negative edge, plus literal expectations from hand-worked vectors.
module tb_bpu_update_queue;
    import bpu_update_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 69;   // {pc[32], type[3], taken, target[32], tgt_wrong}

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    bpu_update_queue_if bus ();
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mis_cnt;
`endif

    bpu_update_queue #(.DEPTH(DEPTH)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef BPU_PERF_CNT_EN
        ,
        .perf_br_cnt  (perf_br_cnt),
        .perf_mis_cnt (perf_mis_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    logic         m_rdv;
    logic [31:0]  m_rdpc;
    logic [31:0]  m_br;
    logic [31:0]  m_mis;
    logic         m_ready;
    logic [W-1:0] h;
    logic         mis0, mis1, tw0, tw1, rd_next;
    logic [31:0]  rdpc_next;

    initial begin
        m_rdv = 0; m_rdpc = 0; m_br = 0; m_mis = 0;
    end

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            m_rdv = 0; m_rdpc = 0; m_br = 0; m_mis = 0;
        end
        m_ready = ((DEPTH - exp_q.size()) >= 2);
        check("cm_ready", bus.cm_ready, m_ready);
        check("redirect_valid", bus.redirect_valid, m_rdv);
        check("redirect_pc", bus.redirect_pc, m_rdpc);
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            check("update_orien_en", bus.update_orien_en, h[36:34] == 3'd1);
            check("retire_pc", bus.retire_pc, h[68:37]);
            check("right_orien", bus.right_orien, h[33]);
            check("branch_mistaken", bus.branch_mistaken, h[0] && h[36:34] != 3'd5);
            check("wrong_pc", bus.wrong_pc, h[68:37]);
            check("right_target", bus.right_target, h[32:1]);
            check("ins_type_w", bus.ins_type_w, h[36:34]);
        end else begin
            check("idle_train_valid", {bus.update_orien_en, bus.branch_mistaken, bus.right_orien}, 0);
            check("idle_train_data", bus.retire_pc | bus.wrong_pc | bus.right_target, 0);
            check("idle_ins_type", bus.ins_type_w, 0);
        end
`ifdef BPU_PERF_CNT_EN
        check("perf_br_cnt", perf_br_cnt, m_br);
        check("perf_mis_cnt", perf_mis_cnt, m_mis);
`endif
        if (resetn) begin
            // Next state after the coming rising edge.
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            rd_next = 0; rdpc_next = 0;
            if (m_ready && bus.cm_valid_0) begin
                tw0  = bus.cm_taken_0 && (bus.cm_pred_target_0 != bus.cm_target_0);
                mis0 = (bus.cm_pred_taken_0 != bus.cm_taken_0) || tw0;
                if (bus.cm_type_0 != 3'd0) begin
                    exp_q.push_back({bus.cm_pc_0, bus.cm_type_0, bus.cm_taken_0, bus.cm_target_0, tw0});
                    m_br++;
                end
                if (mis0) begin
                    rd_next = 1;
                    rdpc_next = bus.cm_taken_0 ? bus.cm_target_0 : bus.cm_pc_0 + 32'd4;
                end else if (bus.cm_valid_1) begin
                    tw1  = bus.cm_taken_1 && (bus.cm_pred_target_1 != bus.cm_target_1);
                    mis1 = (bus.cm_pred_taken_1 != bus.cm_taken_1) || tw1;
                    if (bus.cm_type_1 != 3'd0) begin
                        exp_q.push_back({bus.cm_pc_1, bus.cm_type_1, bus.cm_taken_1, bus.cm_target_1, tw1});
                        m_br++;
                    end
                    if (mis1) begin
                        rd_next = 1;
                        rdpc_next = bus.cm_taken_1 ? bus.cm_target_1 : bus.cm_pc_1 + 32'd4;
                    end
                end
            end
            m_rdv  = rd_next;
            m_rdpc = rdpc_next;
            if (rd_next) m_mis++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.cm_valid_0 = 0; bus.cm_valid_1 = 0;
        bus.cm_pc_0 = 0; bus.cm_pc_1 = 0; bus.cm_type_0 = 0; bus.cm_type_1 = 0;
        bus.cm_taken_0 = 0; bus.cm_taken_1 = 0; bus.cm_target_0 = 0; bus.cm_target_1 = 0;
        bus.cm_pred_taken_0 = 0; bus.cm_pred_taken_1 = 0;
        bus.cm_pred_target_0 = 0; bus.cm_pred_target_1 = 0;
    endtask

    task automatic set_slot(input int slot, input logic [31:0] pc, input logic [2:0] ty,
                            input logic taken, input logic [31:0] target,
                            input logic ptaken, input logic [31:0] ptarget);
        if (slot == 0) begin
            bus.cm_valid_0 = 1; bus.cm_pc_0 = pc; bus.cm_type_0 = ty; bus.cm_taken_0 = taken;
            bus.cm_target_0 = target; bus.cm_pred_taken_0 = ptaken; bus.cm_pred_target_0 = ptarget;
        end else begin
            bus.cm_valid_1 = 1; bus.cm_pc_1 = pc; bus.cm_type_1 = ty; bus.cm_taken_1 = taken;
            bus.cm_target_1 = target; bus.cm_pred_taken_1 = ptaken; bus.cm_pred_target_1 = ptarget;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_call_pair(input int i);
        logic [31:0] pc;
        pc = 32'h2000_0000 + 32'(i) * 32'd8;
        set_slot(0, pc, 3'd3, 1, pc + 32'h40, 1, pc + 32'h40);
        set_slot(1, pc + 32'd4, 3'd3, 1, pc + 32'h44, 1, pc + 32'h44);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int accepted;
        int budget;
        logic rdy;
        resetn = 0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        check("reset_ready", bus.cm_ready, 1);
        check("reset_redirect", bus.redirect_valid, 0);
        check("reset_orien_en", bus.update_orien_en, 0);
        tick();

        // Taken COND predicted not-taken -> redirect to target, trained next cycle.
        set_slot(0, 32'h1c00_0100, 3'd1, 1, 32'h1c00_0200, 0, 32'h1c00_0104);
        tick(); clear_inputs();
        check("t1_redirect_valid", bus.redirect_valid, 1);
        check("t1_redirect_pc", bus.redirect_pc, 32'h1c00_0200);
        check("t1_orien_en", bus.update_orien_en, 1);
        check("t1_right_orien", bus.right_orien, 1);
        check("t1_branch_mistaken", bus.branch_mistaken, 1);
        tick();
        check("t1_redirect_drop", bus.redirect_valid, 0);
        check("t1_train_drop", bus.update_orien_en, 0);

        // COND mispredicted not-taken in slot 0 kills slot 1.
        set_slot(0, 32'h1c00_0100, 3'd1, 0, 32'h1c00_0180, 1, 32'h1c00_0180);
        set_slot(1, 32'h1c00_0200, 3'd2, 1, 32'h1c00_0300, 1, 32'h1c00_0300);
        tick(); clear_inputs();
        check("t2_redirect_pc", bus.redirect_pc, 32'h1c00_0104);
        check("t2_retire_pc", bus.retire_pc, 32'h1c00_0100);
        tick();
        check("t2_single_record", bus.ins_type_w, 0);

        // Indirect with wrong target: redirect, but no target training.
        set_slot(0, 32'h1c00_0300, 3'd5, 1, 32'h1c00_0500, 1, 32'h1c00_0400);
        tick(); clear_inputs();
        check("t4_redirect_valid", bus.redirect_valid, 1);
        check("t4_redirect_pc", bus.redirect_pc, 32'h1c00_0500);
        check("t4_branch_mistaken", bus.branch_mistaken, 0);
        check("t4_ins_type", bus.ins_type_w, 5);
        tick();

        // pc+4 wraps to zero.
        set_slot(0, 32'hFFFF_FFFC, 3'd1, 0, 32'h1234_5678, 1, 32'h1234_5678);
        tick(); clear_inputs();
        check("t5_redirect_valid", bus.redirect_valid, 1);
        check("t5_redirect_pc", bus.redirect_pc, 32'h0000_0000);
        tick();

        // Mixed back-to-back vectors checked by the model.
        set_slot(0, 32'h0000_0100, 3'd0, 0, 32'h0, 0, 32'h0);
        set_slot(1, 32'h0000_0200, 3'd1, 0, 32'h0000_0280, 0, 32'h0);
        tick(); clear_inputs();
        check("mix_nop_skip", bus.retire_pc, 32'h0000_0200);
        set_slot(0, 32'h0000_0300, 3'd4, 1, 32'h0000_0500, 1, 32'h0000_0500);
        set_slot(1, 32'h0000_0304, 3'd3, 1, 32'h0000_0600, 1, 32'h0000_0700);
        tick(); clear_inputs();
        check("mix_slot1_redirect_pc", bus.redirect_pc, 32'h0000_0600);
        set_slot(0, 32'h0000_0400, 3'd1, 1, 32'h0000_0440, 1, 32'h0000_0440);
        set_slot(1, 32'h0000_0440, 3'd0, 0, 32'h0, 0, 32'h0);
        tick(); clear_inputs();
        repeat (6) tick();

        // Dual CALL burst until full.
        accepted = 0;
        budget = 40;
        while (accepted < 6 && budget > 0) begin
            set_call_pair(accepted);
            rdy = bus.cm_ready;
            tick();
            if (rdy) accepted++;
            budget--;
        end
        check("burst_accepted", accepted, 6);
        check("burst_full_ready", bus.cm_ready, 0);
        set_call_pair(6);
        tick(); clear_inputs();
        check("burst_ready_rises", bus.cm_ready, 1);
        repeat (10) tick();

        // Asynchronous reset in the middle of a drain with 5 entries queued.
        for (int i = 0; i < 4; i++) begin
            set_call_pair(10 + i);
            tick();
        end
        clear_inputs();
        check("t6_pre_reset_type", bus.ins_type_w, 3);
        #1 resetn = 0;
        #1;
        check("t6_rst_ready", bus.cm_ready, 1);
        check("t6_rst_type", bus.ins_type_w, 0);
        check("t6_rst_retire_pc", bus.retire_pc, 0);
        check("t6_rst_target", bus.right_target, 0);
        check("t6_rst_redirect", bus.redirect_valid, 0);
`ifdef BPU_PERF_CNT_EN
        check("t6_rst_perf_br", perf_br_cnt, 0);
        check("t6_rst_perf_mis", perf_mis_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        tick();
        check("t6_post_ready", bus.cm_ready, 1);
        check("t6_post_orien_en", bus.update_orien_en, 0);
        check("t6_post_mistaken", bus.branch_mistaken, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
